dmem_store_buffer: RTL and testbench
====================================

// Module: dmem_store_buffer
// PURPOSE
// - Data-memory stage directly downstream of the datapath. It consumes alu_out (address) and dmem_wd (store data),
//   and produces rd (load data) back into the datapath.
// - Stores are posted into a FIFO store buffer and drained to an external word memory over a req/ack handshake.
// - Loads are served by forwarding from the buffer or by a memory read. The datapath is stalled via cpu_stall.
// PARAMETERS
// - SB_DEPTH    4   store-buffer entries; power of 2, >=2
// - ADDR_WIDTH  32  byte-address width; word index = addr[ADDR_WIDTH-1:2]
// PORTS
// - clock      in   1   rising-edge clock
// - reset      in   1   asynchronous, active-low reset
// - cpu_addr   in   32  datapath alu_out (byte address; bits [1:0] ignored)
// - cpu_wd     in   32  datapath dmem_wd
// - cpu_we     in   1   store request
// - cpu_re     in   1   load request
// - cpu_rd     out  32  load data to datapath rd
// - cpu_stall  out  1   datapath must hold this instruction
// - mem_req    out  1   memory transaction valid
// - mem_we     out  1   1=write, 0=read (valid with mem_req)
// - mem_addr   out  30  word address
// - mem_wd     out  32  write data
// - mem_ack    in   1   single-cycle completion; transfer when mem_req&&mem_ack at clock edge
// - mem_rdata  in   32  read data, valid with mem_ack on reads
// - sb_count   out  $clog2(SB_DEPTH)+1  occupied entries
// - sb_empty   out  1   sb_count==0
// BEHAVIOUR
// - Reset (reset==0, async): FIFO pointers and count cleared; buffer contents discarded; FSM goes to IDLE.
//   Outputs at reset: mem_req=0, mem_we=0, mem_addr=0, mem_wd=0, cpu_rd=0, cpu_stall=0, sb_count=0, sb_empty=1.
//   Reset mid-transaction drops mem_req immediately.
// - FIFO: entries are {word_addr, data}. Read/write pointers wrap modulo SB_DEPTH.
//   A push and a pop in the same cycle leave the count unchanged.
// - Store: when cpu_we && count<SB_DEPTH, push at the edge with cpu_stall=0.
//   If full, cpu_stall=1 until a pop frees an entry. An ack in the same cycle does not bypass full.
// - cpu_we && cpu_re together: the store wins and cpu_re is ignored.
// - Hit: a valid entry's word_addr equals cpu_addr[31:2]. On multiple matches the youngest entry wins.
// - FSM states: IDLE, WRITE, READ, RESP. Outputs are registered and held stable while mem_req=1.
//   - IDLE:
//     - If cpu_re && !hit: go to READ with mem_req=1, mem_we=0.
//     - Else if !empty: go to WRITE with head entry, mem_req=1, mem_we=1.
//     - Load has priority over drain.
//   - WRITE: on mem_ack, pop head, go to IDLE with mem_req=0. There is one idle cycle between transactions.
//   - READ: on mem_ack, capture mem_rdata into rdata_q and go to RESP.
//   - RESP: 1 cycle. cpu_rd=rdata_q, cpu_stall=0; next state IDLE.
// - Load miss: cpu_stall=1 from the request cycle through READ.
//   - Minimum latency is 3 cycles (request, READ with immediate ack, RESP).
//   - If a WRITE is in flight, the load waits for its ack first.
// - Load hit: see CONFIGURATION.
// - cpu_rd holds its last value when no load is being delivered. The forwarded value is combinational.
// CONFIGURATION
// - DMEM_SB_FORWARD_EN defined:
//   - A load hit returns the youngest matching entry's data on cpu_rd in the same cycle, cpu_stall=0.
//   - No memory transaction is issued for it.
// - DMEM_SB_FORWARD_EN undefined:
//   - A load hit holds cpu_stall=1. IDLE selects WRITE (drain) while any entry matches.
//   - Once no entry matches, the load proceeds as a miss (READ -> RESP).
// TESTING
// - Reset: assert reset during WRITE (mem_ack=0).
//   -> mem_req=0 same cycle, sb_count=0, sb_empty=1, cpu_rd=0, cpu_stall=0.
// - Forward (EN): store 0x10<-0xDEADBEEF with mem_ack=0, then load 0x10.
//   -> cpu_rd=0xDEADBEEF, cpu_stall=0 that cycle.
//   Without EN: stall until write ack, then mem read; cpu_rd=mem_rdata in RESP.
// - Full: SB_DEPTH=4, mem_ack=0, stores 0x0,0x4,0x8,0xC,0x10 -> sb_count=4, cpu_stall=1 on 5th store.
//   Pulse mem_ack -> mem_addr order 0,1,2,3; 5th store is accepted after the first pop.
// - Load miss: load 0x40, memory acks 3 cycles after mem_req with 0x12345678.
//   -> cpu_stall=1 throughout; RESP shows cpu_rd=0x12345678, cpu_stall=0.
// - Same address: store 0x20<-0x1 then 0x20<-0x2, then load 0x20 (EN).
//   -> cpu_rd=0x2. Memory sees both writes in order 0x1, 0x2.
// - Wrap: 10 stores (data 1..10) with mem_ack tied 1.
//   -> mem_wd sequence 1..10 exactly, sb_empty=1 at end.

Source files
------------

// File: rtl/dmem_store_buffer.sv
// Data-memory stage: posted stores go into a FIFO that drains to word memory over a req/ack port.
// Loads read memory or, with DMEM_SB_FORWARD_EN defined, are forwarded from the buffer on a hit.
module dmem_store_buffer #(
   parameter int SB_DEPTH   = 4,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [ADDR_WIDTH-1:0]     cpu_addr,
   input  logic [31:0]               cpu_wd,
   input  logic                      cpu_we,
   input  logic                      cpu_re,
   output logic [31:0]               cpu_rd,
   output logic                      cpu_stall,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [ADDR_WIDTH-3:0]     mem_addr,
   output logic [31:0]               mem_wd,
   input  logic                      mem_ack,
   input  logic [31:0]               mem_rdata,
   output logic [$clog2(SB_DEPTH):0] sb_count,
   output logic                      sb_empty
);

   localparam int PW = $clog2(SB_DEPTH);
   localparam int CW = PW + 1;
   localparam int WW = ADDR_WIDTH - 2;

   typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

   state_t        state, state_nxt;
   logic [WW-1:0] ent_addr [SB_DEPTH];
   logic [31:0]   ent_data [SB_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr, scan_idx;
   logic [CW-1:0] count;
   logic [WW-1:0] cpu_word, addr_q;
   logic [31:0]   wd_q, rdata_q, hit_data;
   logic          full, empty, push, pop, ld_req, ld_miss, hit, fwd;

   assign cpu_word = cpu_addr[ADDR_WIDTH-1:2];
   assign full     = (count == CW'(SB_DEPTH));
   assign empty    = (count == '0);
   assign ld_req   = cpu_re && !cpu_we;
   assign push     = cpu_we && !full;
   assign pop      = (state == WRITE) && mem_ack;
   assign ld_miss  = ld_req && !hit;

`ifdef DMEM_SB_FORWARD_EN
   assign fwd = ld_req && hit && (state != RESP);
`else
   assign fwd = 1'b0;
`endif

   // Scan oldest to youngest so the last match seen is the youngest entry.
   // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      scan_idx = '0;
      for (int k = 0; k < SB_DEPTH; k++) begin
         scan_idx = rd_ptr + PW'(k);
         if ((CW'(k) < count) && (ent_addr[scan_idx] == cpu_word)) begin
            hit      = 1'b1;
            hit_data = ent_data[scan_idx];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // NOTE: entry storage has no reset; the pointers and count alone decide which entries are valid.
   always_ff @(posedge clock) begin
      if (push) begin
         ent_addr[wr_ptr] <= cpu_word;
         ent_data[wr_ptr] <= cpu_wd;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // A pending load miss takes the port ahead of draining; a hit without forwarding drains first.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (ld_miss)     state_nxt = READ;
            else if (!empty) state_nxt = WRITE;
         end
         WRITE:   if (mem_ack) state_nxt = IDLE;
         READ:    if (mem_ack) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_req = (state == WRITE) || (state == READ);
      mem_we  = (state == WRITE);
      cpu_rd  = fwd ? hit_data : rdata_q;
      if (cpu_we)      cpu_stall = full;
      else if (ld_req) cpu_stall = !((state == RESP) || fwd);
      else             cpu_stall = 1'b0;
   end

   // Transaction fields are latched when leaving IDLE and stay frozen while mem_req is high.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         addr_q  <= '0;
         wd_q    <= '0;
         rdata_q <= '0;
      end else begin
         if (state == IDLE && state_nxt == READ) begin
            addr_q <= cpu_word;
         end else if (state == IDLE && state_nxt == WRITE) begin
            addr_q <= ent_addr[rd_ptr];
            wd_q   <= ent_data[rd_ptr];
         end
         if (state == READ && mem_ack) rdata_q <= mem_rdata;
         else if (fwd)                 rdata_q <= hit_data;
      end
   end

   assign mem_addr = addr_q;
   assign mem_wd   = wd_q;
   assign sb_count = count;
   assign sb_empty = empty;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer; inputs change on the falling edge, outputs are checked 1 ns later.
// Expectations for load hits follow DMEM_SB_FORWARD_EN the same way the design does.
module tb_dmem_store_buffer;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] cpu_addr, cpu_wd, cpu_rd, mem_wd, mem_rdata;
   logic        cpu_we, cpu_re, cpu_stall, mem_req, mem_we, mem_ack, sb_empty;
   logic [29:0] mem_addr;
   logic [2:0]  sb_count;

   int pass_cnt  = 0;
   int total_cnt = 0;
   logic [29:0] log_addr [$];
   logic [31:0] log_wd   [$];

   dmem_store_buffer #(.SB_DEPTH(4), .ADDR_WIDTH(32)) dut (
      .clock(clock), .reset(reset),
      .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_we(cpu_we), .cpu_re(cpu_re),
      .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .sb_count(sb_count), .sb_empty(sb_empty)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

   task automatic step();
      @(negedge clock);
   endtask

   // Let combinational outputs settle, then record any write that completes at the next edge.
   task automatic settle();
      #1;
      if (mem_req && mem_we && mem_ack) begin
         log_addr.push_back(mem_addr);
         log_wd.push_back(mem_wd);
      end
   endtask

   function automatic logic [31:0] wd_at(input int i);
      return (i < log_wd.size()) ? log_wd[i] : 32'hxxxx_xxxx;
   endfunction

   function automatic logic [29:0] addr_at(input int i);
      return (i < log_addr.size()) ? log_addr[i] : 30'hxxxx_xxxx;
   endfunction

   task automatic clear_log();
      log_addr.delete();
      log_wd.delete();
   endtask

   task automatic drain(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         step(); mem_ack = 1'b1; settle();
         if (sb_empty && !mem_req) done = 1'b1;
      end
      mem_ack = 1'b0;
      total_cnt++; if (!done) $display("FAIL %s_drain: got not drained want drained in 100 cycles", name); else pass_cnt++;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      cpu_we = 0; cpu_re = 0; cpu_addr = 0; cpu_wd = 0; mem_ack = 0; mem_rdata = 0;
      step(); step(); settle();
      total_cnt++; if (mem_req !== 1'b0)   $display("FAIL rst_mem_req: got %b want 0", mem_req);   else pass_cnt++;
      total_cnt++; if (mem_we !== 1'b0)    $display("FAIL rst_mem_we: got %b want 0", mem_we);     else pass_cnt++;
      total_cnt++; if (mem_addr !== 30'h0) $display("FAIL rst_mem_addr: got %h want 0", mem_addr); else pass_cnt++;
      total_cnt++; if (mem_wd !== 32'h0)   $display("FAIL rst_mem_wd: got %h want 0", mem_wd);     else pass_cnt++;
      total_cnt++; if (cpu_rd !== 32'h0)   $display("FAIL rst_cpu_rd: got %h want 0", cpu_rd);     else pass_cnt++;
      total_cnt++; if (cpu_stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", cpu_stall);   else pass_cnt++;
      total_cnt++; if (sb_count !== 3'd0)  $display("FAIL rst_count: got %0d want 0", sb_count);   else pass_cnt++;
      total_cnt++; if (sb_empty !== 1'b1)  $display("FAIL rst_empty: got %b want 1", sb_empty);    else pass_cnt++;
      step(); reset = 1'b1; settle();
   endtask

   task automatic test_forward();
      clear_log();
      step(); cpu_we = 1; cpu_addr = 32'h10; cpu_wd = 32'hDEADBEEF; settle();
      total_cnt++; if (cpu_stall !== 1'b0) $display("FAIL fwd_store_stall: got %b want 0", cpu_stall); else pass_cnt++;
      step(); cpu_we = 0; cpu_re = 1; settle();
`ifdef DMEM_SB_FORWARD_EN
      total_cnt++; if (cpu_rd !== 32'hDEADBEEF) $display("FAIL fwd_rd: got %h want deadbeef", cpu_rd); else pass_cnt++;
      total_cnt++; if (cpu_stall !== 1'b0) $display("FAIL fwd_stall: got %b want 0", cpu_stall); else pass_cnt++;
      total_cnt++; if (mem_req !== 1'b0) $display("FAIL fwd_no_req: got %b want 0", mem_req); else pass_cnt++;
      step(); cpu_re = 0; settle();
      total_cnt++; if (cpu_rd !== 32'hDEADBEEF) $display("FAIL fwd_rd_hold: got %h want deadbeef", cpu_rd); else pass_cnt++;
      total_cnt++; if (mem_req !== 1'b1 || mem_we !== 1'b1) $display("FAIL fwd_drain_req: got req=%b we=%b want 1 1", mem_req, mem_we); else pass_cnt++;
      drain("fwd");
`else
      total_cnt++; if (cpu_stall !== 1'b1) $display("FAIL hit_stall: got %b want 1", cpu_stall); else pass_cnt++;
      step(); mem_ack = 1; settle();
      total_cnt++; if (mem_req !== 1'b1 || mem_we !== 1'b1) $display("FAIL hit_write_req: got req=%b we=%b want 1 1", mem_req, mem_we); else pass_cnt++;
      total_cnt++; if (mem_addr !== 30'h4) $display("FAIL hit_write_addr: got %h want 4", mem_addr); else pass_cnt++;
      total_cnt++; if (cpu_stall !== 1'b1) $display("FAIL hit_write_stall: got %b want 1", cpu_stall); else pass_cnt++;
      step(); mem_ack = 0; settle();
      total_cnt++; if (mem_req !== 1'b0) $display("FAIL hit_gap_req: got %b want 0", mem_req); else pass_cnt++;
      total_cnt++; if (cpu_stall !== 1'b1 || sb_empty !== 1'b1) $display("FAIL hit_gap: got stall=%b empty=%b want 1 1", cpu_stall, sb_empty); else pass_cnt++;
      step(); mem_ack = 1; mem_rdata = 32'hCAFEF00D; settle();
      total_cnt++; if (mem_req !== 1'b1 || mem_we !== 1'b0) $display("FAIL hit_read_req: got req=%b we=%b want 1 0", mem_req, mem_we); else pass_cnt++;
      total_cnt++; if (mem_addr !== 30'h4) $display("FAIL hit_read_addr: got %h want 4", mem_addr); else pass_cnt++;
      step(); mem_ack = 0; settle();
      total_cnt++; if (cpu_rd !== 32'hCAFEF00D) $display("FAIL hit_resp_rd: got %h want cafef00d", cpu_rd); else pass_cnt++;
      total_cnt++; if (cpu_stall !== 1'b0) $display("FAIL hit_resp_stall: got %b want 0", cpu_stall); else pass_cnt++;
      step(); cpu_re = 0; settle();
`endif
      total_cnt++; if (log_wd.size() !== 1 || wd_at(0) !== 32'hDEADBEEF) $display("FAIL fwd_mem_write: got n=%0d wd=%h want n=1 wd=deadbeef", log_wd.size(), wd_at(0)); else pass_cnt++;
   endtask

   task automatic test_full();
      clear_log();
      for (int i = 0; i < 4; i++) begin
         step(); cpu_we = 1; cpu_addr = 32'(i * 4); cpu_wd = 32'hA0 + 32'(i); settle();
         total_cnt++; if (cpu_stall !== 1'b0) $display("FAIL full_push%0d_stall: got %b want 0", i, cpu_stall); else pass_cnt++;
      end
      step(); cpu_addr = 32'h10; cpu_wd = 32'hA4; settle();
      total_cnt++; if (sb_count !== 3'd4) $display("FAIL full_count: got %0d want 4", sb_count); else pass_cnt++;
      total_cnt++; if (cpu_stall !== 1'b1) $display("FAIL full_stall: got %b want 1", cpu_stall); else pass_cnt++;
      total_cnt++; if (mem_req !== 1'b1 || mem_addr !== 30'h0) $display("FAIL full_head: got req=%b addr=%h want 1 0", mem_req, mem_addr); else pass_cnt++;
      step(); mem_ack = 1; settle();
      total_cnt++; if (cpu_stall !== 1'b1) $display("FAIL full_ack_no_bypass: got %b want 1", cpu_stall); else pass_cnt++;
      step(); mem_ack = 0; settle();
      total_cnt++; if (cpu_stall !== 1'b0 || sb_count !== 3'd3) $display("FAIL full_after_pop: got stall=%b count=%0d want 0 3", cpu_stall, sb_count); else pass_cnt++;
      step(); cpu_we = 0; settle();
      total_cnt++; if (sb_count !== 3'd4) $display("FAIL full_fifth_in: got %0d want 4", sb_count); else pass_cnt++;
      drain("full");
      for (int i = 0; i < 5; i++) begin
         total_cnt++; if (addr_at(i) !== 30'(i) || wd_at(i) !== 32'hA0 + 32'(i))
            $display("FAIL full_order%0d: got addr=%h wd=%h want addr=%h wd=%h", i, addr_at(i), wd_at(i), 30'(i), 32'hA0 + 32'(i));
         else pass_cnt++;
      end
   endtask

   task automatic test_load_miss();
      step(); cpu_re = 1; cpu_addr = 32'h40; settle();
      total_cnt++; if (cpu_stall !== 1'b1 || mem_req !== 1'b0) $display("FAIL miss_req_cycle: got stall=%b req=%b want 1 0", cpu_stall, mem_req); else pass_cnt++;
      step(); settle();
      total_cnt++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 30'h10) $display("FAIL miss_read: got req=%b we=%b addr=%h want 1 0 10", mem_req, mem_we, mem_addr); else pass_cnt++;
      step(); settle();
      total_cnt++; if (cpu_stall !== 1'b1) $display("FAIL miss_wait_stall: got %b want 1", cpu_stall); else pass_cnt++;
      step(); mem_ack = 1; mem_rdata = 32'h12345678; settle();
      total_cnt++; if (cpu_stall !== 1'b1 || mem_req !== 1'b1) $display("FAIL miss_ack_cycle: got stall=%b req=%b want 1 1", cpu_stall, mem_req); else pass_cnt++;
      step(); mem_ack = 0; mem_rdata = 32'h0; settle();
      total_cnt++; if (cpu_rd !== 32'h12345678) $display("FAIL miss_resp_rd: got %h want 12345678", cpu_rd); else pass_cnt++;
      total_cnt++; if (cpu_stall !== 1'b0 || mem_req !== 1'b0) $display("FAIL miss_resp: got stall=%b req=%b want 0 0", cpu_stall, mem_req); else pass_cnt++;
      step(); cpu_re = 0; settle();
      total_cnt++; if (cpu_rd !== 32'h12345678) $display("FAIL miss_rd_hold: got %h want 12345678", cpu_rd); else pass_cnt++;
   endtask

   task automatic test_same_addr();
      clear_log();
      step(); cpu_we = 1; cpu_addr = 32'h20; cpu_wd = 32'h1; settle();
      step(); cpu_wd = 32'h2; settle();
      step(); cpu_we = 0; cpu_re = 1; settle();
`ifdef DMEM_SB_FORWARD_EN
      total_cnt++; if (cpu_rd !== 32'h2 || cpu_stall !== 1'b0) $display("FAIL same_fwd: got rd=%h stall=%b want 2 0", cpu_rd, cpu_stall); else pass_cnt++;
`else
      total_cnt++; if (cpu_stall !== 1'b1) $display("FAIL same_hit_stall: got %b want 1", cpu_stall); else pass_cnt++;
`endif
      step(); cpu_re = 0; settle();
      drain("same");
      total_cnt++; if (log_wd.size() !== 2 || wd_at(0) !== 32'h1 || wd_at(1) !== 32'h2 || addr_at(1) !== 30'h8)
         $display("FAIL same_order: got n=%0d wd=%h,%h want n=2 wd=1,2", log_wd.size(), wd_at(0), wd_at(1));
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      clear_log();
      step(); mem_ack = 1; settle();
      for (int i = 0; i < 10; i++) begin
         step(); cpu_we = 1; cpu_addr = 32'h100 + 32'(4 * i); cpu_wd = 32'(i + 1); settle();
         for (int g = 0; g < 20 && cpu_stall; g++) begin
            step(); settle();
         end
         total_cnt++; if (cpu_stall !== 1'b0) $display("FAIL wrap_accept%0d: got stall=%b want 0 within 20 cycles", i, cpu_stall); else pass_cnt++;
      end
      step(); cpu_we = 0; settle();
      drain("wrap");
      total_cnt++; if (log_wd.size() !== 10) $display("FAIL wrap_count: got %0d want 10", log_wd.size()); else pass_cnt++;
      for (int i = 0; i < 10; i++) begin
         total_cnt++; if (wd_at(i) !== 32'(i + 1)) $display("FAIL wrap_wd%0d: got %h want %h", i, wd_at(i), 32'(i + 1)); else pass_cnt++;
      end
      total_cnt++; if (sb_empty !== 1'b1) $display("FAIL wrap_empty: got %b want 1", sb_empty); else pass_cnt++;
   endtask

   task automatic test_reset_mid_write();
      step(); cpu_we = 1; cpu_addr = 32'h30; cpu_wd = 32'h55; settle();
      step(); cpu_we = 0; settle();
      step(); settle();
      total_cnt++; if (mem_req !== 1'b1 || mem_we !== 1'b1) $display("FAIL rmw_in_write: got req=%b we=%b want 1 1", mem_req, mem_we); else pass_cnt++;
      reset = 1'b0; #1;
      total_cnt++; if (mem_req !== 1'b0) $display("FAIL rmw_req_drop: got %b want 0", mem_req); else pass_cnt++;
      total_cnt++; if (sb_count !== 3'd0 || sb_empty !== 1'b1) $display("FAIL rmw_fifo: got count=%0d empty=%b want 0 1", sb_count, sb_empty); else pass_cnt++;
      total_cnt++; if (cpu_rd !== 32'h0 || cpu_stall !== 1'b0) $display("FAIL rmw_cpu: got rd=%h stall=%b want 0 0", cpu_rd, cpu_stall); else pass_cnt++;
      total_cnt++; if (mem_addr !== 30'h0 || mem_wd !== 32'h0) $display("FAIL rmw_mem_bus: got addr=%h wd=%h want 0 0", mem_addr, mem_wd); else pass_cnt++;
      step(); reset = 1'b1; settle();
      step(); settle();
      total_cnt++; if (mem_req !== 1'b0) $display("FAIL rmw_discarded: got req=%b want 0", mem_req); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_forward();
      test_full();
      test_load_miss();
      test_same_addr();
      test_wrap();
      test_reset_mid_write();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
